hex_display_ctrl: RTL and testbench

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

---
 rtl/hex_display_ctrl.sv | 157 +++++++++++++++
 tb/tb_hex_display_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// Multi-digit 7-segment controller: captures a hex value on load, then rewrites one digit per cycle.
// Optional blink support is compiled in with `define HEX_DISPLAY_BLINK_EN.
module hex_display_ctrl #(
    parameter int DIGITS    = 6,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  busy,
    output logic                  done
);

    localparam int         IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0] BLANK = 7'h7F;

    // Handshake: load is a level request sampled every rising edge; it is taken
    // only while busy=0 (IDLE), and done pulses for the single cycle after the
    // last digit write, during which a new load is already accepted.
    typedef enum logic {
        IDLE,
        UPDATE
    } state_t;

    state_t               state;
    logic [4*DIGITS-1:0]  shadow;
    logic                 shadow_lz;
    logic [IDX_W-1:0]     index;
    logic [7*DIGITS-1:0]  disp;

    logic [3:0]           cur_nib;
    logic                 cur_blank;
    logic [6:0]           next_pat;
    logic                 last_digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // A digit above 0 is a leading zero when it and every higher nibble are zero.
    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (index == IDX_W'(i)) begin
                cur_nib = shadow[4*i +: 4];
                if (i > 0) begin
                    cur_blank = shadow_lz && ((shadow >> (4*i)) == '0);
                end
            end
        end
        next_pat   = cur_blank ? BLANK : seg_decode(cur_nib);
        last_digit = (index == IDX_W'(DIGITS-1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shadow    <= '0;
            shadow_lz <= 1'b0;
            index     <= '0;
            disp      <= {DIGITS{BLANK}};
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shadow    <= value;
                        shadow_lz <= blank_lz;
                        index     <= '0;
                        busy      <= 1'b1;
                        state     <= UPDATE;
                    end
                end
                UPDATE: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (index == IDX_W'(i)) begin
                            disp[7*i +: 7] <= next_pat;
                        end
                    end
                    if (last_digit) begin
                        index <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HEX_DISPLAY_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;

    // Phase flips once per BLINK_DIV cycles, giving a half-period of BLINK_DIV.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_W'(BLINK_DIV-1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        hex = disp;
        for (int i = 0; i < DIGITS; i++) begin
            if (blink_phase && blink_mask[i]) begin
                hex[7*i +: 7] = BLANK;
            end
        end
    end
`else
    logic unused_blink;

    assign unused_blink = ^{blink_mask, BLINK_DIV[0]};
    assign hex          = disp;
`endif

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl (DIGITS=6, BLINK_DIV=4): vector table plus
// hand-written sequences for overlapping load, mid-update reset and blinking.
module tb_hex_display_ctrl;

    localparam int DIGITS = 6;
    localparam int HW     = 7*DIGITS;
    localparam logic [HW-1:0] ALL_BLANK = {HW{1'b1}};

    typedef struct {
        logic [23:0]   value;
        logic          lz;
        logic [HW-1:0] want;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            load;
    logic [23:0]     value;
    logic            blank_lz;
    logic [5:0]      blink_mask;
    logic [HW-1:0]   hex;
    logic            busy;
    logic            done;

    int              checks   = 0;
    int              failures = 0;
    int              cyc      = 0;
    logic [HW-1:0]   exp_q[$];
    logic [HW-1:0]   shown;
    vec_t            tbl[7];

    always #5 clk = ~clk;

    // Cycles since the last reset edge, for the blink phase model.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    hex_display_ctrl #(.DIGITS(DIGITS), .BLINK_DIV(4)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .blank_lz(blank_lz),
        .blink_mask(blink_mask), .hex(hex), .busy(busy), .done(done)
    );

    function automatic logic [HW-1:0] p6(input logic [6:0] d5, d4, d3, d2, d1, d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts an update from the current negedge and follows it cycle by cycle.
    task automatic run_update(input logic [23:0] v, input logic lz, input logic [HW-1:0] want,
                              input string tag);
        logic [HW-1:0] prev;
        logic [HW-1:0] mask;
        logic [HW-1:0] got_exp;
        prev     = shown;
        value    = v;
        blank_lz = lz;
        load     = 1'b1;
        exp_q.push_back(want);
        for (int j = 0; j <= DIGITS; j++) begin
            tick();
            if (j == 0) load = 1'b0;
            mask = (j == 0) ? '0 : (ALL_BLANK >> (HW - 7*j));
            check($sformatf("%s busy c%0d", tag, j), 64'(busy), 64'(j < DIGITS));
            check($sformatf("%s done c%0d", tag, j), 64'(done), 64'(j == DIGITS));
            check($sformatf("%s hex c%0d", tag, j), 64'(hex), 64'((want & mask) | (prev & ~mask)));
            if (j == DIGITS) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("%s scoreboard empty", tag), 64'(1), 64'(0));
                end else begin
                    got_exp = exp_q.pop_front();
                    check($sformatf("%s final", tag), 64'(hex), 64'(got_exp));
                end
            end
        end
        shown = want;
    endtask

    initial begin
        int            done_cnt;
        logic [HW-1:0] v1_want;
        logic [6:0]    d0_want;

        tbl[0] = '{24'h12AF05, 1'b0, p6(7'h79, 7'h24, 7'h08, 7'h0E, 7'h40, 7'h12)};
        tbl[1] = '{24'h000305, 1'b1, p6(7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12)};
        tbl[2] = '{24'h000000, 1'b1, p6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40)};
        tbl[3] = '{24'h000305, 1'b0, p6(7'h40, 7'h40, 7'h40, 7'h30, 7'h40, 7'h12)};
        tbl[4] = '{24'hFEDCBA, 1'b1, p6(7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08)};
        tbl[5] = '{24'h987654, 1'b0, p6(7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19)};
        tbl[6] = '{24'h010000, 1'b1, p6(7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40)};
        v1_want = tbl[0].want;

        reset      = 1'b1;
        load       = 1'b0;
        value      = '0;
        blank_lz   = 1'b0;
        blink_mask = '0;
        tick();
        tick();
        check("reset hex", 64'(hex), 64'(ALL_BLANK));
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        reset = 1'b0;
        shown = ALL_BLANK;
        tick();

        // Consecutive entries start on the done cycle of the previous one.
        for (int k = 0; k < 7; k++) begin
            run_update(tbl[k].value, tbl[k].lz, tbl[k].want, $sformatf("vec%0d", k));
        end

        // Second load two cycles into an update must be dropped.
        tick();
        value    = 24'h000000;
        blank_lz = 1'b1;
        run_update(24'h000305, 1'b1, tbl[1].want, "pre_ign");
        tick();
        value    = 24'h12AF05;
        blank_lz = 1'b0;
        load     = 1'b1;
        done_cnt = 0;
        for (int j = 0; j < 14; j++) begin
            tick();
            if (j == 0) load = 1'b0;
            if (j == 1) begin
                load     = 1'b1;
                value    = 24'h987654;
                blank_lz = 1'b1;
            end
            if (j == 2) load = 1'b0;
            if (done) done_cnt++;
            if (j == 6) check("ign done at c6", 64'(done), 64'(1));
        end
        check("ign single done", 64'(done_cnt), 64'(1));
        check("ign idle after", 64'(busy), 64'(0));
        check("ign first value", 64'(hex), 64'(v1_want));
        shown = v1_want;

        // Reset at update cycle 3 aborts without done.
        value = 24'h987654;
        blank_lz = 1'b0;
        load  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            load = 1'b0;
        end
        reset = 1'b1;
        tick();
        check("abort hex", 64'(hex), 64'(ALL_BLANK));
        check("abort busy", 64'(busy), 64'(0));
        check("abort done", 64'(done), 64'(0));
        reset    = 1'b0;
        done_cnt = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (done) done_cnt++;
        end
        check("abort no done", 64'(done_cnt), 64'(0));
        check("abort hex held", 64'(hex), 64'(ALL_BLANK));

        // Reset wins over a simultaneous load.
        reset = 1'b1;
        load  = 1'b1;
        value = 24'h12AF05;
        tick();
        reset = 1'b0;
        load  = 1'b0;
        check("rst prio busy", 64'(busy), 64'(0));
        tick();
        check("rst prio busy2", 64'(busy), 64'(0));
        check("rst prio hex", 64'(hex), 64'(ALL_BLANK));
        shown = ALL_BLANK;

        run_update(24'h12AF05, 1'b0, v1_want, "pre_blink");
        tick();
        blink_mask = 6'b000001;
        for (int k = 0; k < 24; k++) begin
            tick();
`ifdef HEX_DISPLAY_BLINK_EN
            d0_want = (((cyc / 4) % 2) == 1) ? 7'h7F : 7'h12;
`else
            d0_want = 7'h12;
`endif
            check($sformatf("blink d0 s%0d", k), 64'(hex[6:0]), 64'(d0_want));
            check($sformatf("blink upper s%0d", k), 64'(hex[HW-1:7]), 64'(v1_want[HW-1:7]));
        end
        blink_mask = '0;

        if (exp_q.size() != 0) check("scoreboard leftover", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
